// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index width and operand-forwarding source codes.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  // 2'b11 is deliberately left unused; no stage ever drives it.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit outputs bundled for the datapath: forwarding selects, stall controls, stall counter.
interface hazard_unit_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
);

  fwd_t             forwardA;
  fwd_t             forwardB;
  fwd_t             fwd_store;
  logic             pc_wen;
  logic             ifid_wen;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_count;

  modport hazard_unit (
    output forwardA, forwardB, fwd_store, pc_wen, ifid_wen, idex_flush, stall_count
  );

  modport datapath (
    input forwardA, forwardB, fwd_store, pc_wen, ifid_wen, idex_flush, stall_count
  );

endinterface

// File: rtl/hazard_unit_fwd_select.sv
// Forwarding select for one EX operand; EX/MEM beats MEM/WB so the youngest value wins.
module fwd_select
  import cpu_types_pkg::*;
(
  input  regbits_t src,
  input  logic     exmem_wen,
  input  regbits_t exmem_dst,
  input  logic     mem_wen,
  input  regbits_t mem_dst,
  output fwd_t     fwd
);

   // NOTE: assign a default first so every path drives fwd and no latch is inferred.
   always_comb begin
      fwd = FWD_NONE;
      if (exmem_wen && (exmem_dst != '0) && (exmem_dst == src)) begin
         fwd = FWD_MEM;
      end else if (mem_wen && (mem_dst != '0) && (mem_dst == src)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// MIPS 5-stage hazard unit: EX operand forwarding, load-use stall/bubble, saturating stall counter.
module hazard_unit
  import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  regbits_t                  idex_rs,
   input  regbits_t                  idex_rt,
   input  logic                      MemRead,
   input  regbits_t                  ifid_rs,
   input  regbits_t                  ifid_rt,
   input  logic                      exmem_RegWEN,
   input  regbits_t                  exmem_RegDst,
   input  logic                      mem_RegWEN,
   input  regbits_t                  mem_RegDst,
   input  logic                      idex_MemWrite,
   input  regbits_t                  stall_rt,
   hazard_unit_if.hazard_unit        huif
);

   fwd_t             fwd_a;
   fwd_t             fwd_b;
   logic             stall;
   logic [CNT_W-1:0] stall_count_d;
   logic [CNT_W-1:0] stall_count_q;

   fwd_select u_fwd_a (
      .src       (idex_rs),
      .exmem_wen (exmem_RegWEN),
      .exmem_dst (exmem_RegDst),
      .mem_wen   (mem_RegWEN),
      .mem_dst   (mem_RegDst),
      .fwd       (fwd_a)
   );

   fwd_select u_fwd_b (
      .src       (idex_rt),
      .exmem_wen (exmem_RegWEN),
      .exmem_dst (exmem_RegDst),
      .mem_wen   (mem_RegWEN),
      .mem_dst   (mem_RegDst),
      .fwd       (fwd_b)
   );

   // A load into $0 never produces a real dependency.
   assign stall = MemRead && (stall_rt != '0) &&
                  ((stall_rt == ifid_rs) || (stall_rt == ifid_rt));

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign huif.forwardA    = fwd_a;
   assign huif.forwardB    = fwd_b;
   assign huif.fwd_store   = idex_MemWrite ? fwd_b : FWD_NONE;
   assign huif.pc_wen      = !stall;
   assign huif.ifid_wen    = !stall;
   assign huif.idex_flush  = stall;
   assign huif.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed and random vectors against a behavioural model.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  typedef struct {
    logic     rst;
    regbits_t idex_rs, idex_rt, ifid_rs, ifid_rt;
    logic     mem_read, mem_write;
    logic     exmem_wen, mem_wen;
    regbits_t exmem_dst, mem_dst, stall_rt;
  } vec_t;

  typedef struct {
    logic [1:0]  fa, fb, fs;
    logic        pc_wen, ifid_wen, flush;
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  vec_t cur;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  longint model_cnt32 = 0;
  longint model_cnt4  = 0;

  hazard_unit_if #(.CNT_W(32)) hif32 ();
  hazard_unit_if #(.CNT_W(4))  hif4 ();

  hazard_unit #(.CNT_W(32)) dut32 (
    .CLK(clk), .nRST(cur.rst),
    .idex_rs(cur.idex_rs), .idex_rt(cur.idex_rt), .MemRead(cur.mem_read),
    .ifid_rs(cur.ifid_rs), .ifid_rt(cur.ifid_rt),
    .exmem_RegWEN(cur.exmem_wen), .exmem_RegDst(cur.exmem_dst),
    .mem_RegWEN(cur.mem_wen), .mem_RegDst(cur.mem_dst),
    .idex_MemWrite(cur.mem_write), .stall_rt(cur.stall_rt),
    .huif(hif32)
  );

  hazard_unit #(.CNT_W(4)) dut4 (
    .CLK(clk), .nRST(cur.rst),
    .idex_rs(cur.idex_rs), .idex_rt(cur.idex_rt), .MemRead(cur.mem_read),
    .ifid_rs(cur.ifid_rs), .ifid_rt(cur.ifid_rt),
    .exmem_RegWEN(cur.exmem_wen), .exmem_RegDst(cur.exmem_dst),
    .mem_RegWEN(cur.mem_wen), .mem_RegDst(cur.mem_dst),
    .idex_MemWrite(cur.mem_write), .stall_rt(cur.stall_rt),
    .huif(hif4)
  );

  // Reference model: search in-flight writers youngest-first for the operand register.
  function automatic logic [1:0] model_fwd(vec_t v, regbits_t src);
    logic       wen[2];
    regbits_t   dst[2];
    logic [1:0] code[2];
    wen[0] = v.exmem_wen; dst[0] = v.exmem_dst; code[0] = 2'b10;
    wen[1] = v.mem_wen;   dst[1] = v.mem_dst;   code[1] = 2'b01;
    if (src == 0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (wen[i] && dst[i] == src) return code[i];
    return 2'b00;
  endfunction

  function automatic bit model_stall(vec_t v);
    int load_dst = v.mem_read ? int'(v.stall_rt) : 0;
    return load_dst != 0 && (load_dst == int'(v.ifid_rs) || load_dst == int'(v.ifid_rt));
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v.rst = 0; v.idex_rs = 0; v.idex_rt = 0; v.ifid_rs = 0; v.ifid_rt = 0;
    v.mem_read = 0; v.mem_write = 0; v.exmem_wen = 0; v.mem_wen = 0;
    v.exmem_dst = 0; v.mem_dst = 0; v.stall_rt = 0;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.rst       = ($urandom_range(0, 15) == 0);
    v.idex_rs   = regbits_t'($urandom_range(0, 3));
    v.idex_rt   = regbits_t'($urandom_range(0, 3));
    v.ifid_rs   = regbits_t'($urandom_range(0, 3));
    v.ifid_rt   = regbits_t'($urandom_range(0, 3));
    v.exmem_dst = regbits_t'($urandom_range(0, 3));
    v.mem_dst   = regbits_t'($urandom_range(0, 3));
    v.stall_rt  = regbits_t'($urandom_range(0, 3));
    v.mem_read  = 1'($urandom_range(0, 1));
    v.mem_write = 1'($urandom_range(0, 1));
    v.exmem_wen = 1'($urandom_range(0, 1));
    v.mem_wen   = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Advance the model across one clock edge, then apply a new vector and queue its expectation.
  task automatic step(vec_t v);
    exp_t e;
    @(posedge clk);
    if (cur.rst) begin
      model_cnt32 = 0;
      model_cnt4  = 0;
    end else if (model_stall(cur)) begin
      if (model_cnt32 < 64'hFFFF_FFFF) model_cnt32++;
      if (model_cnt4 < 15) model_cnt4++;
    end
    #1;
    cur = v;
    e.fa       = model_fwd(v, v.idex_rs);
    e.fb       = model_fwd(v, v.idex_rt);
    e.fs       = v.mem_write ? e.fb : 2'b00;
    e.pc_wen   = !model_stall(v);
    e.ifid_wen = !model_stall(v);
    e.flush    = model_stall(v);
    e.cnt32    = 32'(model_cnt32);
    e.cnt4     = 4'(model_cnt4);
    sb.push_back(e);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("forwardA",      64'(hif32.forwardA),    64'(e.fa));
      check("forwardB",      64'(hif32.forwardB),    64'(e.fb));
      check("fwd_store",     64'(hif32.fwd_store),   64'(e.fs));
      check("pc_wen",        64'(hif32.pc_wen),      64'(e.pc_wen));
      check("ifid_wen",      64'(hif32.ifid_wen),    64'(e.ifid_wen));
      check("idex_flush",    64'(hif32.idex_flush),  64'(e.flush));
      check("stall_count32", 64'(hif32.stall_count), 64'(e.cnt32));
      check("stall_count4",  64'(hif4.stall_count),  64'(e.cnt4));
      check("w4_forwardA",   64'(hif4.forwardA),     64'(e.fa));
      check("w4_pc_wen",     64'(hif4.pc_wen),       64'(e.pc_wen));
    end
  end

  initial begin
    vec_t v;
    int   budget;
    cur = idle();
    cur.rst = 1;

    // Reset state.
    v = idle(); v.rst = 1; step(v);

    // EX/MEM forwarding on A only.
    v = idle(); v.exmem_wen = 1; v.exmem_dst = 5; v.idex_rs = 5; v.idex_rt = 6; step(v);
    // MEM/WB forwarding on B, then EX/MEM priority.
    v = idle(); v.mem_wen = 1; v.mem_dst = 6; v.idex_rt = 6; step(v);
    v.exmem_wen = 1; v.exmem_dst = 6; step(v);
    // $0 is never forwarded or stalled on.
    v = idle(); v.exmem_wen = 1; v.mem_wen = 1; step(v);
    v = idle(); v.mem_read = 1; step(v);
    // Load-use stall for one cycle, then release.
    v = idle(); v.mem_read = 1; v.stall_rt = 8; v.ifid_rt = 8; step(v);
    v.mem_read = 0; step(v);
    // Store-data forwarding and its gating.
    v = idle(); v.mem_write = 1; v.idex_rt = 9; v.exmem_dst = 9; v.exmem_wen = 1; step(v);
    v.mem_write = 0; step(v);

    // Three stall cycles, then a one-edge reset that still shows the stall.
    v = idle(); v.rst = 1; step(v);
    v = idle(); v.mem_read = 1; v.stall_rt = 3; v.ifid_rs = 3;
    v.exmem_wen = 1; v.exmem_dst = 4; v.idex_rs = 4;
    for (int i = 0; i < 3; i++) step(v);
    v.rst = 1; step(v);
    v = idle(); step(v);
    step(v);

    // Saturation of the narrow counter.
    v = idle(); v.mem_read = 1; v.stall_rt = 2; v.ifid_rt = 2;
    for (int i = 0; i < 20; i++) step(v);
    v = idle(); step(v);

    for (int i = 0; i < 400; i++) step(rand_vec());

    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
